// File: rtl/pct_pkg.sv
// pct_pkg: shared types and helpers for pipe_commit_tracker.
// The optional flush feature of the tracker is enabled by defining PCT_FLUSH_EN.
package pct_pkg;

    typedef enum logic [1:0] {
        PCT_IDLE,
        PCT_START,
        PCT_STARTED
    } pct_state_e;

    localparam int PCT_DEF_STAGES = 4;
    localparam int PCT_DEF_PIPES  = 2;

    // Flat bit index of stall_S<k> (k is 1-based) for pipe p.
    function automatic int stall_idx(input int p, input int k,
                                     input int num_stages = PCT_DEF_STAGES);
        return p * num_stages + (k - 1);
    endfunction

endpackage

// File: rtl/pipe_commit_tracker_if.sv
// pipe_commit_tracker_if: observation bus between the monitored pipes and the tracker.
// PCT_FLUSH_EN adds the per-pipe flush_i signal.
interface pipe_commit_tracker_if
    import pct_pkg::*;
#(
    parameter int NUM_PIPES  = PCT_DEF_PIPES,
    parameter int NUM_STAGES = PCT_DEF_STAGES,
    parameter int CNT_W      = 8
);
    logic                            issue_i;
    logic [NUM_PIPES-1:0]            valid_s1_i;
    logic [NUM_PIPES*NUM_STAGES-1:0] stall_i;
    logic                            start_o;
    logic                            started_o;
    logic [NUM_PIPES*NUM_STAGES-1:0] stage_tok_o;
    logic [NUM_PIPES-1:0]            commit_o;
    logic [CNT_W-1:0]                cycle_cnt_o;
    logic                            ended_o;
    logic                            second_end_o;
    logic                            timeout_o;

`ifdef PCT_FLUSH_EN
    logic [NUM_PIPES-1:0]            flush_i;

    modport master (
        output issue_i, valid_s1_i, stall_i, flush_i,
        input  start_o, started_o, stage_tok_o, commit_o, cycle_cnt_o,
               ended_o, second_end_o, timeout_o
    );
    modport slave (
        input  issue_i, valid_s1_i, stall_i, flush_i,
        output start_o, started_o, stage_tok_o, commit_o, cycle_cnt_o,
               ended_o, second_end_o, timeout_o
    );
`else
    modport master (
        output issue_i, valid_s1_i, stall_i,
        input  start_o, started_o, stage_tok_o, commit_o, cycle_cnt_o,
               ended_o, second_end_o, timeout_o
    );
    modport slave (
        input  issue_i, valid_s1_i, stall_i,
        output start_o, started_o, stage_tok_o, commit_o, cycle_cnt_o,
               ended_o, second_end_o, timeout_o
    );
`endif

endinterface

// File: rtl/pct_stage_chain.sv
// pct_stage_chain: shadows one tagged token through the stall-gated stages of a single pipe.
// With PCT_FLUSH_EN defined, flush_i clears the chain and blocks that cycle's capture/commit.
module pct_stage_chain #(
    parameter int NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture_i,
    input  logic [NUM_STAGES-1:0] stall_i,
`ifdef PCT_FLUSH_EN
    input  logic                  flush_i,
`endif
    output logic [NUM_STAGES-1:0] tok_o,
    output logic                  commit_o
);
    // tok_q[k] shadows stage k+1; stage 1 is never registered.
    logic [NUM_STAGES-1:1] tok_q, tok_d;
    logic [NUM_STAGES-1:0] nxt;
    logic                  tok1;
    logic                  commit_q, commit_d;
    logic                  flush;

`ifdef PCT_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign tok1 = capture_i & ~stall_i[0] & ~flush;

    // Stage handoff: a stage reloads from its predecessor only when it is not stalled.
    always_comb begin
        nxt      = '0;
        tok_d    = tok_q;
        nxt[0]   = tok1;
        for (int k = 1; k < NUM_STAGES; k++) begin
            nxt[k] = tok_q[k] & ~stall_i[k];
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (!stall_i[k]) begin
                tok_d[k] = nxt[k-1];
            end
        end
        if (flush) begin
            tok_d = '0;
        end
        commit_d = nxt[NUM_STAGES-1] & ~flush;
    end

    // Token and retire-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_q    <= '0;
            commit_q <= 1'b0;
        end else begin
            tok_q    <= tok_d;
            commit_q <= commit_d;
        end
    end

    assign tok_o    = {tok_q, tok1};
    assign commit_o = commit_q;

endmodule

// File: rtl/pipe_commit_tracker.sv
// pipe_commit_tracker: observational commit monitor for the L2 pipelines.
// Tags the first stage-1 instruction after a start pulse, shadows it per pipe and
// reports start/end/second-end/timeout plus a saturating cycle count.
// Define PCT_FLUSH_EN to add per-pipe flush of the shadow tokens.
//
// state       | meaning
// PCT_IDLE    | waiting for issue_i
// PCT_START   | one-cycle capture window (start_o)
// PCT_STARTED | run in progress; terminal until reset
module pipe_commit_tracker
    import pct_pkg::*;
#(
    parameter int NUM_PIPES  = PCT_DEF_PIPES,
    parameter int NUM_STAGES = PCT_DEF_STAGES,
    parameter int CNT_W      = 8,
    parameter int MAX_CYCLES = 132,
    parameter int END_BOUND  = 50,
    parameter int END_PIPE   = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    pipe_commit_tracker_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] END_C = CNT_W'(END_BOUND);

    pct_state_e                      state_q, state_d;
    logic                            start, started;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            ended_q, ended_d;
    logic                            second_q, second_d;
    logic                            timeout_q, timeout_d;
    logic [NUM_PIPES-1:0]            commit;
    logic [NUM_PIPES*NUM_STAGES-1:0] tok_all;

    // Run FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PCT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run FSM next state and decoded run outputs.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        started = 1'b0;
        case (state_q)
            PCT_IDLE: begin
                if (bus.issue_i) begin
                    state_d = PCT_START;
                end
            end
            PCT_START: begin
                start   = 1'b1;
                state_d = PCT_STARTED;
            end
            PCT_STARTED: begin
                started = 1'b1;
            end
            default: state_d = PCT_IDLE;
        endcase
    end

    // Saturating cycle counter and sticky end/timeout flags.
    always_comb begin
        cnt_d = cnt_q;
        if ((start | started) && (cnt_q < MAX_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        ended_d   = ended_q | (commit[END_PIPE] & started & (cnt_q <= END_C));
        // A commit in the cycle that sets ended_q sees ended_q still low, so it cannot count twice.
        second_d  = second_q | (commit[END_PIPE] & started & ended_q);
        timeout_d = timeout_q | (started & ~ended_q & (cnt_q > END_C));
    end

    // Counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            ended_q   <= 1'b0;
            second_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ended_q   <= ended_d;
            second_q  <= second_d;
            timeout_q <= timeout_d;
        end
    end

    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
        logic [NUM_STAGES-1:0] stall_p;
        for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stall
            assign stall_p[k-1] = bus.stall_i[stall_idx(p, k, NUM_STAGES)];
        end
        pct_stage_chain #(
            .NUM_STAGES(NUM_STAGES)
        ) u_chain (
            .clk       (clk),
            .rst_n     (rst_n),
            .capture_i (start & bus.valid_s1_i[p]),
            .stall_i   (stall_p),
`ifdef PCT_FLUSH_EN
            .flush_i   (bus.flush_i[p]),
`endif
            .tok_o     (tok_all[p*NUM_STAGES +: NUM_STAGES]),
            .commit_o  (commit[p])
        );
    end

    assign bus.start_o      = start;
    assign bus.started_o    = started;
    assign bus.stage_tok_o  = tok_all;
    assign bus.commit_o     = commit;
    assign bus.cycle_cnt_o  = cnt_q;
    assign bus.ended_o      = ended_q;
    assign bus.second_end_o = second_q;
    assign bus.timeout_o    = timeout_q;

endmodule

// File: tb/tb_pipe_commit_tracker.sv
// tb_pipe_commit_tracker: directed and randomized checks of pipe_commit_tracker
// against a token-position model of the tracked instruction.
module tb_pipe_commit_tracker;
    localparam int NP   = 2;
    localparam int NS   = 4;
    localparam int CW   = 8;
    localparam int MAXC = 132;
    localparam int EB   = 50;
    localparam int EP   = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_commit_tracker_if #(.NUM_PIPES(NP), .NUM_STAGES(NS), .CNT_W(CW)) bus ();

    pipe_commit_tracker #(
        .NUM_PIPES(NP), .NUM_STAGES(NS), .CNT_W(CW),
        .MAX_CYCLES(MAXC), .END_BOUND(EB), .END_PIPE(EP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // model: run phase 0=idle 1=start window 2=running; m_pos = stage holding token (0 = none)
    int m_phase, m_cnt;
    int m_pos [NP];
    bit m_commit [NP];
    bit m_ended, m_second, m_timeout;

    // observed events of the current run (cycle numbers counted from the release of reset)
    int cyc;
    int start_first, start_cnt, ended_first, timeout_first, tok3_cnt;
    int first_commit [NP];
    int commit_cnt [NP];
    int cnt_log [0:299];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0;
        m_ended = 0; m_second = 0; m_timeout = 0;
        for (int p = 0; p < NP; p++) begin
            m_pos[p] = 0; m_commit[p] = 0;
        end
    endtask

    task automatic clear_log();
        cyc = 0; start_first = -1; start_cnt = 0;
        ended_first = -1; timeout_first = -1; tok3_cnt = 0;
        for (int p = 0; p < NP; p++) begin
            first_commit[p] = -1; commit_cnt[p] = 0;
        end
        for (int i = 0; i < 300; i++) cnt_log[i] = -1;
    endtask

    task automatic drive_idle();
        bus.issue_i = 1'b0; bus.valid_s1_i = '0; bus.stall_i = '0;
`ifdef PCT_FLUSH_EN
        bus.flush_i = '0;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_log();
    endtask

    // One cycle: drive inputs, compare every output mid-cycle, then advance the model.
    task automatic step(input logic iss, input logic [NP-1:0] vld,
                        input logic [NP*NS-1:0] stl, input logic [NP-1:0] fl_req);
        logic [NP-1:0]    fl;
        logic [NP-1:0]    cap;
        logic [NP*NS-1:0] etok;
        bit               run, c_end;
        int               k;
        bus.issue_i = iss; bus.valid_s1_i = vld; bus.stall_i = stl;
`ifdef PCT_FLUSH_EN
        fl = fl_req;
        bus.flush_i = fl;
`else
        fl = '0;
        if (fl_req != '0) fl = '0;
`endif
        @(negedge clk);
        etok = '0;
        for (int p = 0; p < NP; p++) begin
            cap[p] = (m_phase == 1) && vld[p] && !stl[p*NS] && !fl[p];
            etok[p*NS] = cap[p];
            for (int s = 2; s <= NS; s++) etok[p*NS+s-1] = (m_pos[p] == s);
        end
        chk("start_o",      32'(bus.start_o),      32'(m_phase == 1));
        chk("started_o",    32'(bus.started_o),    32'(m_phase == 2));
        chk("stage_tok_o",  32'(bus.stage_tok_o),  32'(etok));
        chk("commit_o",     32'(bus.commit_o),     32'({m_commit[1], m_commit[0]}));
        chk("cycle_cnt_o",  32'(bus.cycle_cnt_o),  32'(m_cnt));
        chk("ended_o",      32'(bus.ended_o),      32'(m_ended));
        chk("second_end_o", 32'(bus.second_end_o), 32'(m_second));
        chk("timeout_o",    32'(bus.timeout_o),    32'(m_timeout));

        if (bus.start_o) begin
            start_cnt++;
            if (start_first < 0) start_first = cyc;
        end
        for (int p = 0; p < NP; p++) begin
            if (bus.commit_o[p]) begin
                commit_cnt[p]++;
                if (first_commit[p] < 0) first_commit[p] = cyc;
            end
        end
        if (bus.stage_tok_o[2]) tok3_cnt++;
        if (bus.ended_o && ended_first < 0) ended_first = cyc;
        if (bus.timeout_o && timeout_first < 0) timeout_first = cyc;
        if (cyc < 300) cnt_log[cyc] = int'(bus.cycle_cnt_o);

        run   = (m_phase == 2);
        c_end = m_commit[EP];
        if (c_end && run && m_ended) m_second = 1;
        if (run && !m_ended && m_cnt > EB) m_timeout = 1;
        if (c_end && run && m_cnt <= EB) m_ended = 1;
        if (m_phase >= 1 && m_cnt < MAXC) m_cnt++;
        if (m_phase == 0 && iss) m_phase = 1;
        else if (m_phase == 1) m_phase = 2;
        for (int p = 0; p < NP; p++) begin
            m_commit[p] = 0;
            if (fl[p]) begin
                m_pos[p] = 0;
            end else begin
                k = m_pos[p];
                if (k >= 2 && !stl[p*NS+k-1]) begin
                    if (k == NS) begin
                        m_commit[p] = 1; m_pos[p] = 0;
                    end else if (stl[p*NS+k]) begin
                        m_pos[p] = 0;
                    end else begin
                        m_pos[p] = k + 1;
                    end
                end
                if (cap[p] && !stl[p*NS+1]) m_pos[p] = 2;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NP*NS-1:0] stl;
        logic [NP-1:0]    vld, fl;
        logic             iss;

        // Test 1: plain run, no stalls
        do_reset();
        chk("reset cnt", 32'(bus.cycle_cnt_o), 32'd0);
        chk("reset tok", 32'(bus.stage_tok_o), 32'd0);
        step(1'b1, '0, '0, '0);
        step(1'b0, 2'b01, '0, '0);
        idle_steps(10);
        chk("t1 start cycle", start_first, 1);
        chk("t1 commit cycle", first_commit[0], 5);
        chk("t1 commit count", commit_cnt[0], 1);
        chk("t1 ended cycle", ended_first, 6);
        chk("t1 cnt at cyc6", cnt_log[6], 5);

        // Test 2: stall_S3 of pipe0 during cycles 3-4
        do_reset();
        step(1'b1, '0, '0, '0);
        step(1'b0, 2'b01, '0, '0);
        step(1'b0, '0, '0, '0);
        stl = '0; stl[2] = 1'b1;
        step(1'b0, '0, stl, '0);
        step(1'b0, '0, stl, '0);
        idle_steps(8);
        chk("t2 commit cycle", first_commit[0], 7);
        chk("t2 commit count", commit_cnt[0], 1);
        chk("t2 tok3 cycles", tok3_cnt, 3);

        // Test 3: nothing captured -> timeout and saturation
        do_reset();
        step(1'b1, '0, '0, '0);
        idle_steps(139);
        chk("t3 cnt at cyc52", cnt_log[52], 51);
        chk("t3 timeout cycle", timeout_first, 53);
        chk("t3 saturated cnt", cnt_log[139], 132);
        chk("t3 never ended", ended_first, -1);

        // Test 4: both pipes capture, pipe1 stalled at S2 for 2 cycles
        do_reset();
        step(1'b1, '0, '0, '0);
        step(1'b0, 2'b11, '0, '0);
        stl = '0; stl[NS+1] = 1'b1;
        step(1'b0, '0, stl, '0);
        step(1'b0, '0, stl, '0);
        idle_steps(8);
        chk("t4 pipe0 commit", first_commit[0], 5);
        chk("t4 pipe1 commit", first_commit[1], 7);
        chk("t4 ended cycle", ended_first, 6);

        // Test 5: a repeated issue after the commit starts nothing
        do_reset();
        step(1'b1, '0, '0, '0);
        step(1'b0, 2'b01, '0, '0);
        idle_steps(4);
        for (int i = 0; i < 7; i++) step(1'b1, 2'b11, '0, '0);
        idle_steps(6);
        chk("t5 start count", start_cnt, 1);
        chk("t5 commit count", commit_cnt[0], 1);
        chk("t5 second_end", 32'(bus.second_end_o), 32'd0);

        // Test 6: asynchronous reset mid-flight
        do_reset();
        step(1'b1, '0, '0, '0);
        step(1'b0, 2'b01, '0, '0);
        step(1'b0, '0, '0, '0);
        rst_n = 1'b0;
        #1;
        chk("t6 rst start",   32'(bus.start_o),     32'd0);
        chk("t6 rst started", 32'(bus.started_o),   32'd0);
        chk("t6 rst tok",     32'(bus.stage_tok_o), 32'd0);
        chk("t6 rst commit",  32'(bus.commit_o),    32'd0);
        chk("t6 rst cnt",     32'(bus.cycle_cnt_o), 32'd0);
        chk("t6 rst flags",   32'({bus.ended_o, bus.second_end_o, bus.timeout_o}), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_log();
        idle_steps(10);
        chk("t6 no restart", start_cnt, 0);

`ifdef PCT_FLUSH_EN
        // Test 6b: flush pipe0 while its token is in flight
        do_reset();
        step(1'b1, '0, '0, '0);
        step(1'b0, 2'b01, '0, '0);
        step(1'b0, '0, '0, '0);
        step(1'b0, '0, '0, 2'b01);
        idle_steps(56);
        chk("t6b commit count", commit_cnt[0], 0);
        chk("t6b timeout cycle", timeout_first, 53);
`endif

        // Randomized runs
        for (int r = 0; r < 24; r++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                iss = ($urandom_range(0, 3) == 0);
                vld = NP'($urandom());
                stl = '0;
                for (int b = 0; b < NP*NS; b++) stl[b] = ($urandom_range(0, 5) == 0);
                fl = '0;
                for (int b = 0; b < NP; b++) fl[b] = ($urandom_range(0, 24) == 0);
                step(iss, vld, stl, fl);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
